// File: rtl/iter_sqacc_seq.sv
// iter_sqacc_seq: sequential square-accumulate engine. Runs acc = (acc + comp)^2
// ITERS times, one iteration per clock. The result is 0 when in_cond is clear.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_cond/in_comp request
// side; out_valid/out_ready/out_data result side; busy (RUN or DONE);
// hist (accepted in_cond bits, newest in bit 0).
// Macro ITER_SQACC_OVERLAP_EN: in DONE, accept a new request in the same cycle
// as the result handshake.
module iter_sqacc_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cond,
  input  logic [WIDTH-1:0] in_comp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [9:0]       hist
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [9:0] LAST = 10'(ITERS - 1);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] comp_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sq;
  logic [9:0]       cnt;
  logic             last;
  logic             accept;
  logic             out_hs;

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    s        = acc + comp_q;
    sq       = s * s;
    last     = (cnt == LAST);
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN:  in_ready = 1'b0;
      DONE: begin
`ifdef ITER_SQACC_OVERLAP_EN
        in_ready = out_ready;
`else
        in_ready = 1'b0;
`endif
      end
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    unique case (state)
      IDLE: begin
        if (accept) state_d = in_cond ? RUN : DONE;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_hs) state_d = IDLE;
        // An overlapping accept overrides the return to IDLE.
        if (accept) state_d = in_cond ? RUN : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      comp_q   <= '0;
      out_data <= '0;
      hist     <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        comp_q <= in_comp;
        hist   <= {hist[8:0], in_cond};
        acc    <= '0;
        cnt    <= '0;
        if (!in_cond) out_data <= '0;
      end else if (state == RUN) begin
        acc <= sq;
        cnt <= cnt + 10'd1;
        if (last) out_data <= sq;
      end
    end
  end

endmodule

// File: tb/tb_iter_sqacc_seq.sv
// tb_iter_sqacc_seq: randomized and directed checks of iter_sqacc_seq
// against a plain-arithmetic reference model, for ITERS = 10, 3, 2, 1.
module tb_iter_sqacc_seq;

  localparam int IT [4] = '{10, 3, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  out_ready = '0;
  logic        in_cond = 1'b0;
  logic [31:0] in_comp = '0;
  logic        in_ready [4];
  logic        out_valid [4];
  logic        busy [4];
  logic [31:0] out_data [4];
  logic [9:0]  hist [4];
  logic [9:0]  hm [4];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    iter_sqacc_seq #(
      .WIDTH(32),
      .ITERS(g == 0 ? 10 : (g == 1 ? 3 : (g == 2 ? 2 : 1)))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_cond  (in_cond),
      .in_comp  (in_comp),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g]),
      .hist     (hist[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int it, input bit c,
                                        input logic [31:0] v);
    logic [31:0] a;
    a = 0;
    if (!c) return 0;
    for (int i = 0; i < it; i++) a = (a + v) * (a + v);
    return a;
  endfunction

  task automatic send(input int k, input bit c, input logic [31:0] v,
                      output int lat);
    @(negedge clk);
    chk("ready", 32'(in_ready[k]), 1);
    in_valid[k] = 1'b1;
    in_cond = c;
    in_comp = v;
    @(negedge clk);
    lat = 1;
    in_valid[k] = 1'b0;
    in_comp = $urandom;
    in_cond = 1'($urandom);
    hm[k] = {hm[k][8:0], c};
    while (!out_valid[k] && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take(input int k);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("ovclr", 32'(out_valid[k]), 0);
  endtask

  task automatic req(input string tag, input int k, input bit c,
                     input logic [31:0] v);
    int lat;
    send(k, c, v, lat);
    chk({tag, "_lat"}, 32'(lat), c ? 32'(IT[k] + 1) : 1);
    chk({tag, "_data"}, out_data[k], model(IT[k], c, v));
    chk({tag, "_hist"}, 32'(hist[k]), 32'(hm[k]));
    take(k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] od;
    logic [31:0] q [$];
    logic [9:0]  h0;
    int          t [3];
    int          n;
    int          guard;
    int          acc_n;
    int          chk_n;
    bit          a;
    bit          h;
    for (int k = 0; k < 4; k++) hm[k] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ov", 32'(out_valid[0]), 0);
    chk("rst_od", out_data[0], 0);
    chk("rst_hist", 32'(hist[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready[0]), 1);

    req("pre", 0, 1'b1, 32'h5);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_cond = 1'b1;
    in_comp = 32'h7;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ov", 32'(out_valid[0]), 0);
    chk("mid_od", out_data[0], 0);
    chk("mid_hist", 32'(hist[0]), 0);
    chk("mid_busy", 32'(busy[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) hm[k] = '0;
    #1 chk("mid_rdy", 32'(in_ready[0]), 1);
    req("clean", 0, 1'b1, 32'h9);

    req("cond0", 1, 1'b0, 32'h1234);
    chk("cond0_h0", 32'(hist[1][0]), 0);
    req("it3", 1, 1'b1, 32'h1);
    chk("it3_25", out_data[1], 25);
    req("it2", 2, 1'b1, 32'h2);
    chk("it2_36", out_data[2], 36);
    req("it1", 3, 1'b1, 32'hFFFF_FFFF);
    chk("it1_wrap", out_data[3], 1);

    begin
      int lat;
      send(1, 1'b1, 32'h3, lat);
      chk("bp_lat", 32'(lat), 4);
      od = out_data[1];
      h0 = hist[1];
      chk("bp_data", od, model(3, 1'b1, 32'h3));
      for (int i = 0; i < 5; i++) begin
        in_valid[1] = (i % 2 == 0);
        in_comp = $urandom;
        #1;
        chk("bp_rdy", 32'(in_ready[1]), 0);
        @(negedge clk);
        chk("bp_stable", out_data[1], od);
        chk("bp_ov", 32'(out_valid[1]), 1);
        chk("bp_hist", 32'(hist[1]), 32'(h0));
      end
      in_valid[1] = 1'b0;
      take(1);
      chk("bp_keep", out_data[1], od);
      @(negedge clk);
      chk("bp_single", 32'(out_valid[1]), 0);
    end

    acc_n = 0;
    chk_n = 0;
    guard = 0;
    while ((acc_n < 50 || chk_n < acc_n) && guard < 20000) begin
      @(negedge clk);
      out_ready[0] = 1'($urandom_range(0, 1));
      in_valid[0] = (acc_n < 50) && ($urandom_range(0, 2) != 0);
      in_cond = ($urandom_range(0, 3) != 0);
      in_comp = $urandom;
      #1;
      a = in_valid[0] && in_ready[0];
      h = out_valid[0] && out_ready[0];
      od = out_data[0];
      @(posedge clk);
      if (h) begin
        if (q.size() > 0) chk("rand", od, q.pop_front());
        else chk("spurious", 1, 0);
        chk_n++;
      end
      if (a) begin
        q.push_back(model(10, in_cond, in_comp));
        hm[0] = {hm[0][8:0], in_cond};
        acc_n++;
      end
      guard++;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    chk("rand_cnt", 32'(chk_n), 50);
    chk("rand_hist", 32'(hist[0]), 32'(hm[0]));

    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_cond = 1'b1;
    in_comp = 32'h3;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 200) begin
      #1;
      if (in_ready[0]) begin
        t[n] = cyc;
        n++;
        hm[0] = {hm[0][8:0], 1'b1};
      end
      @(negedge clk);
      guard++;
    end
    in_valid[0] = 1'b0;
    chk("per_n", 32'(n), 3);
`ifdef ITER_SQACC_OVERLAP_EN
    chk("per1", 32'(t[1] - t[0]), 11);
    chk("per2", 32'(t[2] - t[1]), 11);
`else
    chk("per1", 32'(t[1] - t[0]), 12);
    chk("per2", 32'(t[2] - t[1]), 12);
`endif
    repeat (15) @(negedge clk);
    out_ready[0] = 1'b0;
    chk("per_idle", 32'(busy[0]), 0);
    chk("per_hist", 32'(hist[0]), 32'(hm[0]));
    chk("per_data", out_data[0], model(10, 1'b1, 32'h3));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
